// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory load/store/copy sequencer:
// request op encodings, FSM states and default bus widths.
package data_mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_COPY  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_RD  = 3'd1,
        LD_CAP = 3'd2,
        ST_WR  = 3'd3,
        CP_RD  = 3'd4,
        CP_WR  = 3'd5
    } state_t;

endpackage

// File: rtl/data_mem_ctrl.sv
// Load/store/copy sequencer in front of a synchronous data memory with a
// one-cycle registered read; returns exactly one response per request.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_dst,
    input  logic [7:0]        req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state;
    state_t            next_state;
    logic              accept;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [7:0]        count;
    logic [DATA_W-1:0] wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values,
            // independent of process evaluation order.
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        next_state = state;
        accept     = 1'b0;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    case (req_op)
                        OP_LOAD:  next_state = LD_RD;
                        OP_STORE: next_state = ST_WR;
                        OP_COPY:  next_state = (req_len != 8'd0) ? CP_RD : IDLE;
                        default:  next_state = IDLE;
                    endcase
                end
            end
            LD_RD: begin
                mem_read   = 1'b1;
                mem_addr   = src_addr;
                next_state = LD_CAP;
            end
            LD_CAP: begin
                next_state = IDLE;
            end
            ST_WR: begin
                mem_write  = 1'b1;
                mem_addr   = src_addr;
                mem_wdata  = wdata_q;
                next_state = IDLE;
            end
            CP_RD: begin
                mem_read   = 1'b1;
                mem_addr   = src_addr;
                next_state = CP_WR;
            end
            CP_WR: begin
                // Memory output is the byte fetched in the preceding CP_RD.
                mem_write  = 1'b1;
                mem_addr   = dst_addr;
                mem_wdata  = mem_rdata;
                next_state = (count == 8'd1) ? IDLE : CP_RD;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_addr  <= '0;
            dst_addr  <= '0;
            count     <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;

            if (accept) begin
                src_addr <= req_addr;
                dst_addr <= req_dst;
                count    <= req_len;
                wdata_q  <= req_wdata;
                if (req_op == OP_RSVD) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end else if (req_op == OP_COPY && req_len == 8'd0) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                end
            end

            case (state)
                LD_CAP: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= mem_rdata;
                end
                ST_WR: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= wdata_q;
                end
                CP_WR: begin
                    // rsp_rdata doubles as the copy hold register; it is only
                    // meaningful once rsp_valid rises after the final byte.
                    rsp_rdata <= mem_rdata;
                    src_addr  <= src_addr + ADDR_W'(1);
                    dst_addr  <= dst_addr + ADDR_W'(1);
                    count     <= count - 8'd1;
                    if (count == 8'd1) begin
                        rsp_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed table, hand-written multi-cycle corner
// cases and randomized requests against a byte-array reference model.
module tb_data_mem_ctrl;
    import data_mem_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_addr;
    logic [7:0] req_dst;
    logic [7:0] req_len;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    data_mem_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_dst(req_dst), .req_len(req_len),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // 256x8 synchronous memory with registered read data.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int bad_strobe = 0;

    logic [7:0]  ref_mem [256];
    logic [16:0] ev_q [$];
    logic [16:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Strobe monitor: records every memory access as {write, addr, wdata}.
    always @(negedge clk) begin
        if (mem_read && mem_write) bad_strobe++;
        if (!mem_read && !mem_write && (mem_addr != 8'h00 || mem_wdata != 8'h00)) bad_strobe++;
        if (mem_read || mem_write) ev_q.push_back({mem_write, mem_addr, mem_wdata});
    end

    // Reference: what the request does to memory, its accesses and its response.
    task automatic model_req(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] l, input logic [7:0] w,
                             output logic [7:0] rd, output logic er, output int lat);
        logic [7:0] s, t, v;
        exp_q.delete();
        rd = 8'h00;
        er = 1'b0;
        lat = 1;
        case (op)
            2'b00: begin
                exp_q.push_back({1'b0, a, 8'h00});
                rd = ref_mem[a];
                lat = 3;
            end
            2'b01: begin
                exp_q.push_back({1'b1, a, w});
                ref_mem[a] = w;
                rd = w;
                lat = 2;
            end
            2'b10: begin
                for (int i = 0; i < int'(l); i++) begin
                    s = a + 8'(i);
                    t = d + 8'(i);
                    v = ref_mem[s];
                    exp_q.push_back({1'b0, s, 8'h00});
                    exp_q.push_back({1'b1, t, v});
                    ref_mem[t] = v;
                    rd = v;
                end
                lat = (l == 8'd0) ? 1 : 2 * int'(l) + 1;
            end
            default: er = 1'b1;
        endcase
    endtask

    task automatic do_req(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] l, input logic [7:0] w,
                          output logic [7:0] rd, output logic er, output int lat);
        int guard = 0;
        ev_q.delete();
        rd = 8'h00;
        er = 1'b0;
        lat = 0;
        @(negedge clk);
        req_op = op; req_addr = a; req_dst = d; req_len = l; req_wdata = w;
        req_valid = 1'b1;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            check("rsp_timeout", 32'(rsp_valid), 32'd1);
            return;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk);
        check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    endtask

    task automatic run_req(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] l, input logic [7:0] w,
                           output logic [7:0] rd, output logic er, output int lat,
                           output logic [7:0] m_rd, output logic m_er, output int m_lat);
        int nmis = 0;
        model_req(op, a, d, l, w, m_rd, m_er, m_lat);
        do_req(op, a, d, l, w, rd, er, lat);
        check("strobe_count", 32'(ev_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
            if (ev_q[i] !== exp_q[i]) nmis++;
        check("strobe_seq", 32'(nmis), 32'd0);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] dst;
        logic [7:0] len;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [7:0] rd, m_rd, orig;
        logic       er, m_er;
        int         lat, m_lat, seen, nmis;

        vecs[0]  = '{2'b01, 8'h10, 8'h00, 8'd0, 8'hA5, 8'hA5, 1'b0, 2};
        vecs[1]  = '{2'b00, 8'h10, 8'h00, 8'd0, 8'h00, 8'hA5, 1'b0, 3};
        vecs[2]  = '{2'b01, 8'h00, 8'h00, 8'd0, 8'h11, 8'h11, 1'b0, 2};
        vecs[3]  = '{2'b01, 8'h01, 8'h00, 8'd0, 8'h22, 8'h22, 1'b0, 2};
        vecs[4]  = '{2'b01, 8'h02, 8'h00, 8'd0, 8'h33, 8'h33, 1'b0, 2};
        vecs[5]  = '{2'b01, 8'h03, 8'h00, 8'd0, 8'h44, 8'h44, 1'b0, 2};
        vecs[6]  = '{2'b10, 8'h00, 8'h80, 8'd4, 8'h00, 8'h44, 1'b0, 9};
        vecs[7]  = '{2'b00, 8'h83, 8'h00, 8'd0, 8'h00, 8'h44, 1'b0, 3};
        vecs[8]  = '{2'b11, 8'h55, 8'h66, 8'd3, 8'h77, 8'h00, 1'b1, 1};
        vecs[9]  = '{2'b10, 8'h20, 8'h30, 8'd0, 8'h00, 8'h00, 1'b0, 1};
        vecs[10] = '{2'b01, 8'hFE, 8'h00, 8'd0, 8'h61, 8'h61, 1'b0, 2};
        vecs[11] = '{2'b01, 8'hFF, 8'h00, 8'd0, 8'h62, 8'h62, 1'b0, 2};
        vecs[12] = '{2'b01, 8'h00, 8'h00, 8'd0, 8'h63, 8'h63, 1'b0, 2};
        vecs[13] = '{2'b10, 8'hFE, 8'h01, 8'd3, 8'h00, 8'h63, 1'b0, 7};
        vecs[14] = '{2'b00, 8'h01, 8'h00, 8'd0, 8'h00, 8'h61, 1'b0, 3};
        vecs[15] = '{2'b00, 8'h03, 8'h00, 8'd0, 8'h00, 8'h63, 1'b0, 3};

        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 2'b00; req_addr = 8'h00; req_dst = 8'h00; req_len = 8'd0; req_wdata = 8'h00;

        #2;
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 32'd0);
        check("reset_mem_bus", {mem_read, mem_write, mem_addr, mem_wdata}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            run_req(vecs[i].op, vecs[i].addr, vecs[i].dst, vecs[i].len, vecs[i].wdata,
                    rd, er, lat, m_rd, m_er, m_lat);
            if (!vecs[i].exp_err) check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("copy_dst_%0d", i), 32'(mem[8'h80 + 8'(i)]), 32'(8'h11 * (i + 1)));

        // Back-to-back stores with req_valid held high.
        @(negedge clk);
        req_op = 2'b01; req_addr = 8'h20; req_wdata = 8'h5A; req_valid = 1'b1;
        check("b2b_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("b2b_busy", 32'(req_ready), 32'd0);
        check("b2b_no_early_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("b2b_rsp1", {rsp_valid, req_ready, rsp_rdata}, {22'd0, 1'b1, 1'b1, 8'h5A});
        req_addr = 8'h21; req_wdata = 8'hC3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_second_write", {rsp_valid, mem_write, mem_addr, mem_wdata}, {15'd0, 1'b0, 1'b1, 8'h21, 8'hC3});
        @(negedge clk);
        check("b2b_rsp2", {rsp_valid, rsp_rdata}, {23'd0, 1'b1, 8'hC3});
        ref_mem[8'h20] = 8'h5A;
        ref_mem[8'h21] = 8'hC3;

        // Reset in the middle of an 8-byte copy, after 3 bytes were written.
        for (int i = 0; i < 8; i++) begin
            mem[8'h40 + 8'(i)] = 8'hB0 + 8'(i);
            ref_mem[8'h40 + 8'(i)] = 8'hB0 + 8'(i);
        end
        orig = mem[8'hC3];
        @(negedge clk);
        req_op = 2'b10; req_addr = 8'h40; req_dst = 8'hC0; req_len = 8'd8; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_read", {mem_read, mem_addr}, {23'd0, 1'b1, 8'h43});
        #1 rst = 1'b1;
        #1;
        check("rst_async_bus", {mem_read, mem_write, mem_addr, mem_wdata}, 32'd0);
        check("rst_async_ctl", {req_ready, rsp_valid, rsp_err}, 32'd4);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("rst_no_rsp", 32'(seen), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_written_%0d", i), 32'(mem[8'hC0 + 8'(i)]), 32'(8'hB0 + 8'(i)));
            ref_mem[8'hC0 + 8'(i)] = 8'hB0 + 8'(i);
        end
        check("rst_untouched", 32'(mem[8'hC3]), 32'(orig));

        // Randomized requests against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            logic [7:0] a, d, l, w;
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            d  = 8'($urandom);
            l  = 8'($urandom_range(0, 10));
            w  = 8'($urandom);
            run_req(op, a, d, l, w, rd, er, lat, m_rd, m_er, m_lat);
            if (!m_er) check($sformatf("rand%0d_rdata", n), 32'(rd), 32'(m_rd));
            check($sformatf("rand%0d_err", n), 32'(er), 32'(m_er));
            check($sformatf("rand%0d_lat", n), 32'(lat), 32'(m_lat));
        end

        nmis = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i]) nmis++;
        check("final_mem_image", 32'(nmis), 32'd0);
        check("strobe_rules", 32'(bad_strobe), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
